// File: rtl/lcd_pkg.sv
// Shared wb_lcd writer definitions: refresh FSM states, default display address and patterns.
package lcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } lcd_state_e;

  localparam logic [7:0] LCD_BAR_BASE  = 8'h90;
  localparam logic [7:0] LCD_FILL_PAT  = 8'hFF;
  localparam logic [7:0] LCD_EMPTY_PAT = 8'h00;

  // Display RAM address of a segment; wraps within the 8-bit address space.
  function automatic logic [7:0] seg_addr(input logic [7:0] base, input logic [7:0] idx);
    return base + idx;
  endfunction

endpackage

// File: rtl/lcd_bar_gauge_if.sv
// Level/handshake/strobe bundle between the bar gauge renderer and its neighbours.
interface lcd_bar_gauge_if #(
  parameter int LVL_W = 3
);
  logic [LVL_W-1:0] level;
  logic             lcd_busy;
  logic             dr;
  logic             wr;
  logic [7:0]       direc;
  logic [7:0]       dbi;
  logic             busy;
  logic             done;

  modport master (
    output level, lcd_busy,
    input  dr, wr, direc, dbi, busy, done
  );

  modport slave (
    input  level, lcd_busy,
    output dr, wr, direc, dbi, busy, done
  );
endinterface

// File: rtl/lcd_blink_timer.sv
// Low-battery blink divider and phase toggle; exists only when LCD_BAR_BLINK_EN is defined.
`ifdef LCD_BAR_BLINK_EN
module lcd_blink_timer #(
  parameter int DIV = 10_000_000
) (
  input  logic clk2,
  input  logic rst,
  input  logic clr_i,
  output logic toggle_o,
  output logic blink_ph_o
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ph_q, ph_d;
  logic             wrap;

  assign wrap       = (cnt_q == CNT_W'(DIV - 1)) && !clr_i;
  assign toggle_o   = wrap;
  assign blink_ph_o = ph_q;

  // Divider next state: held at zero while a nonzero level is shown.
  always_comb begin
    cnt_d = cnt_q;
    ph_d  = ph_q;
    if (clr_i) begin
      cnt_d = {CNT_W{1'b0}};
      ph_d  = 1'b0;
    end else if (wrap) begin
      cnt_d = {CNT_W{1'b0}};
      ph_d  = ~ph_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      ph_d  = ph_q;
    end
  end

  // Divider and phase registers.
  always_ff @(posedge clk2) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
      ph_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ph_q  <= ph_d;
    end
  end

endmodule
`endif

// File: rtl/lcd_bar_gauge.sv
// Bar-graph renderer: rewrites SEGS display bytes whenever the level changes.
// Optional low-battery blink of segment 0 at level 0 under LCD_BAR_BLINK_EN.
module lcd_bar_gauge
  import lcd_pkg::*;
#(
  parameter int         SEGS      = 4,
  parameter int         LVL_W     = 3,
  parameter logic [7:0] BASE_ADDR = LCD_BAR_BASE,
  parameter logic [7:0] FILL_PAT  = LCD_FILL_PAT,
  parameter logic [7:0] EMPTY_PAT = LCD_EMPTY_PAT
`ifdef LCD_BAR_BLINK_EN
  ,
  parameter int         BLINK_DIV = 10_000_000
`endif
) (
  input logic            clk2,
  input logic            rst,
  lcd_bar_gauge_if.slave bus
);

  localparam int IDX_W = $clog2(SEGS + 1);

  lcd_state_e       state_q, state_d;
  logic [LVL_W-1:0] level;
  logic [LVL_W-1:0] lvl_prev_q;
  logic             pending_q, pending_d;
  logic [IDX_W-1:0] lvl_lat_q, lvl_lat_d;
  logic [IDX_W-1:0] seg_q, seg_d;
  logic [IDX_W-1:0] lvl_clamp;
  logic             dr_q, dr_d, wr_q, wr_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [7:0]       direc_q, direc_d, dbi_q, dbi_d;
  logic             start, level_chg, last_seg, seg_lit;
  logic             blink_tog, blink_ph;

  assign level     = bus.level;
  assign level_chg = (level != lvl_prev_q);
  assign start     = (state_q == IDLE) && pending_q && !bus.lcd_busy;
  assign last_seg  = (seg_q == IDX_W'(SEGS - 1));

`ifdef LCD_BAR_BLINK_EN
  lcd_blink_timer #(
    .DIV (BLINK_DIV)
  ) u_blink (
    .clk2       (clk2),
    .rst        (rst),
    .clr_i      (lvl_lat_q != {IDX_W{1'b0}}),
    .toggle_o   (blink_tog),
    .blink_ph_o (blink_ph)
  );
`else
  assign blink_tog = 1'b0;
  assign blink_ph  = 1'b0;
`endif

  // blink_ph can only be set while the latched level is zero.
  assign seg_lit = (seg_q < lvl_lat_q) || ((seg_q == {IDX_W{1'b0}}) && blink_ph);

  // Level clamp to the segment count.
  always_comb begin
    if (32'(level) > SEGS) begin
      lvl_clamp = IDX_W'(SEGS);
    end else begin
      lvl_clamp = IDX_W'(level);
    end
  end

  // State and output registers.
  always_ff @(posedge clk2) begin
    if (rst) begin
      state_q    <= IDLE;
      lvl_prev_q <= {LVL_W{1'b0}};
      pending_q  <= 1'b1;
      lvl_lat_q  <= {IDX_W{1'b0}};
      seg_q      <= {IDX_W{1'b0}};
      dr_q       <= 1'b0;
      wr_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      direc_q    <= 8'h00;
      dbi_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      lvl_prev_q <= level;
      pending_q  <= pending_d;
      lvl_lat_q  <= lvl_lat_d;
      seg_q      <= seg_d;
      dr_q       <= dr_d;
      wr_q       <= wr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      direc_q    <= direc_d;
      dbi_q      <= dbi_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ADDR;
        end else begin
          state_d = IDLE;
        end
      end
      ADDR: begin
        if (!bus.lcd_busy) begin
          state_d = DATA;
        end else begin
          state_d = ADDR;
        end
      end
      DATA: begin
        if (bus.lcd_busy) begin
          state_d = DATA;
        end else if (last_seg) begin
          state_d = DONE;
        end else begin
          state_d = ADDR;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values; a refresh start consumes any change seen in the same cycle.
  always_comb begin
    dr_d      = 1'b0;
    wr_d      = 1'b0;
    done_d    = 1'b0;
    busy_d    = busy_q;
    direc_d   = direc_q;
    dbi_d     = dbi_q;
    seg_d     = seg_q;
    lvl_lat_d = lvl_lat_q;
    if (start) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q | level_chg | blink_tog;
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          lvl_lat_d = lvl_clamp;
          seg_d     = {IDX_W{1'b0}};
          busy_d    = 1'b1;
        end else begin
          busy_d    = 1'b0;
        end
      end
      ADDR: begin
        if (!bus.lcd_busy) begin
          dr_d    = 1'b1;
          direc_d = seg_addr(BASE_ADDR, 8'(seg_q));
        end else begin
          dr_d    = 1'b0;
        end
      end
      DATA: begin
        if (!bus.lcd_busy) begin
          wr_d  = 1'b1;
          dbi_d = seg_lit ? FILL_PAT : EMPTY_PAT;
          if (!last_seg) begin
            seg_d = seg_q + IDX_W'(1);
          end else begin
            seg_d = seg_q;
          end
        end else begin
          wr_d  = 1'b0;
        end
      end
      DONE: begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  assign bus.dr    = dr_q;
  assign bus.wr    = wr_q;
  assign bus.direc = direc_q;
  assign bus.dbi   = dbi_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule
